// File: rtl/mult_datapath.sv
// Repeated-addition multiplier datapath: operand registers A and B (down-counter),
// product accumulator P, and the eqz/busy status returned to the control FSM.
module mult_datapath #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 ld_a,
   input  logic                 ld_b,
   input  logic                 ld_p,
   input  logic                 dec,
   input  logic                 clr,
   output logic                 eqz,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   logic [WIDTH-1:0]   a_reg, a_next;
   logic [WIDTH-1:0]   b_reg, b_next;
   logic [2*WIDTH-1:0] p_reg, p_next;
   logic               busy_reg, busy_next;
   logic               b_zero;

   assign b_zero = (b_reg == '0);

   always_comb begin
      a_next    = a_reg;
      b_next    = b_reg;
      p_next    = p_reg;
      busy_next = busy_reg;

      if (ld_a)
         a_next = data_in;

      if (ld_b)
         b_next = data_in;
      else if (dec && !b_zero)
         b_next = b_reg - 1'b1;

      // Accumulation is gated by B != 0 so the cycle in which the FSM
      // observes eqz cannot add one extra A; a_reg is the pre-edge value.
      if (clr)
         p_next = '0;
      else if (ld_p && !b_zero)
         p_next = p_reg + {{WIDTH{1'b0}}, a_reg};

      if (ld_b)
         busy_next = (data_in != '0);
      else if (dec && (b_reg == WIDTH'(1)))
         busy_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         p_reg    <= '0;
         busy_reg <= 1'b0;
      end else begin
         a_reg    <= a_next;
         b_reg    <= b_next;
         p_reg    <= p_next;
         busy_reg <= busy_next;
      end
   end

   assign eqz     = b_zero;
   assign product = p_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: directed scenarios plus randomized
// control traffic against a behavioural model of the A/B/P/busy state.
module tb_mult_datapath;

   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [WIDTH-1:0]   data_in;
   logic               ld_a, ld_b, ld_p, dec, clr;
   logic               eqz;
   logic [2*WIDTH-1:0] product;
   logic               busy;

   int vectors_applied = 0;
   int miscompares     = 0;

   // reference state
   int unsigned m_a, m_b, m_p;
   bit          m_busy;

   mult_datapath #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .ld_a    (ld_a),
      .ld_b    (ld_b),
      .ld_p    (ld_p),
      .dec     (dec),
      .clr     (clr),
      .eqz     (eqz),
      .product (product),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors_applied++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_p = 0; m_busy = 0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".product"}, 32'(product), m_p);
      check({tag, ".eqz"},     32'(eqz),     32'(m_b == 0));
      check({tag, ".busy"},    32'(busy),    32'(m_busy));
   endtask

   // One clock: drive controls, take the edge, advance the model, compare.
   task automatic step(input string tag, input int unsigned d,
                       input bit la, input bit lb, input bit lp, input bit dc, input bit cl);
      int unsigned old_a, old_b;
      data_in = WIDTH'(d);
      ld_a = la; ld_b = lb; ld_p = lp; dec = dc; clr = cl;
      @(posedge clk);
      old_a = m_a;
      old_b = m_b;
      if (la) m_a = d;
      if (lb) begin
         m_b    = d;
         m_busy = (d != 0);
      end else if (dc && old_b > 0) begin
         m_b = old_b - 1;
         if (m_b == 0) m_busy = 0;
      end
      if (cl)
         m_p = 0;
      else if (lp && old_b > 0)
         m_p = m_p + old_a;
      #1;
      check_state(tag);
      $display("step %-8s d=%0d ld_a=%0b ld_b=%0b ld_p=%0b dec=%0b clr=%0b -> product=%0d eqz=%0b busy=%0b",
               tag, d, la, lb, lp, dc, cl, product, eqz, busy);
   endtask

   task automatic do_run(input string tag, input int unsigned a, input int unsigned b);
      step(tag, a, 1, 0, 0, 0, 0);
      step(tag, b, 0, 1, 0, 0, 1);
      for (int i = 0; i < int'(b); i++) begin
         check({tag, ".eqz_early"}, 32'(eqz), 32'(b == 0));
         step(tag, 0, 0, 0, 1, 1, 0);
      end
      check({tag, ".result"}, 32'(product), a * b);
      check({tag, ".eqz_end"}, 32'(eqz), 1);
      check({tag, ".busy_end"}, 32'(busy), 0);
   endtask

   initial begin
      int unsigned d;
      rst = 1'b0;
      data_in = '0;
      {ld_a, ld_b, ld_p, dec, clr} = '0;
      model_reset();
      #12;
      check_state("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // basic 5*3 followed by two guarded extra cycles
      do_run("basic", 5, 3);
      step("guard", 0, 0, 0, 1, 1, 0);
      step("guard", 0, 0, 0, 1, 1, 0);
      check("guard.product", 32'(product), 15);

      // clr wins over ld_p
      step("clr_lp", 0, 0, 1, 0, 0, 0);
      step("clr_lp", 2, 0, 1, 0, 0, 0);
      step("clr_lp", 0, 0, 0, 1, 0, 1);
      check("clr_lp.p", 32'(product), 0);

      // ld_b wins over dec; then count down exactly 7
      step("ldb_dec", 7, 0, 1, 0, 1, 0);
      for (int i = 0; i < 7; i++) begin
         check("ldb_dec.eqz_low", 32'(eqz), 0);
         step("ldb_dec", 0, 0, 0, 0, 1, 0);
      end
      check("ldb_dec.eqz_high", 32'(eqz), 1);

      // zero multiplier
      step("zero_b", 9, 1, 0, 0, 0, 0);
      step("zero_b", 0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step("zero_b", 0, 0, 0, 1, 1, 0);
         check("zero_b.busy", 32'(busy), 0);
      end
      check("zero_b.product", 32'(product), 0);

      // zero multiplicand
      do_run("zero_a", 0, 5);

      // maximum operands
      do_run("max", 255, 255);
      check("max.product", 32'(product), 65025);

      // asynchronous reset mid-run at A=4, B=6, P=8
      step("rst_mid", 4, 1, 0, 0, 0, 0);
      step("rst_mid", 6, 0, 1, 0, 0, 1);
      step("rst_mid", 0, 0, 0, 1, 1, 0);
      step("rst_mid", 0, 0, 0, 1, 1, 0);
      check("rst_mid.p_before", 32'(product), 8);
      #3 rst = 1'b0;
      model_reset();
      #1;
      check_state("rst_mid.async");
      #1 rst = 1'b1;
      {ld_a, ld_b, ld_p, dec, clr} = '0;
      do_run("after_rst", 2, 2);

      // back-to-back runs without reset
      do_run("b2b_1", 6, 7);
      do_run("b2b_2", 3, 3);

      // random full runs checked against plain multiplication
      for (int r = 0; r < 8; r++)
         do_run("rand_run", $urandom_range(0, 255), $urandom_range(0, 40));

      // random control traffic against the model
      for (int i = 0; i < 300; i++) begin
         d = $urandom_range(0, 15);
         step("rand", d,
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 1) == 0),
              ($urandom_range(0, 1) == 0),
              ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
Datapath for the repeated-addition multiplier. It consumes ld_a, ld_b, ld_p, dec and clr from the multiplier control FSM and returns eqz to it. Both operands arrive serially on a shared data_in bus. P accumulates A once per cycle while B counts down to zero, so the final product is A*B.

Parameters:
WIDTH, 8, operand width in bits; the product is 2*WIDTH bits.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-low.
data_in  input  WIDTH  shared operand bus; sampled into A on ld_a and into B on ld_b.
ld_a  input  1  load A from data_in.
ld_b  input  1  load B (down-counter) from data_in.
ld_p  input  1  accumulate: P <= P + A (zero-extended).
dec  input  1  decrement B by 1.
clr  input  1  synchronous clear of P.
eqz  output  1  combinational, high when B == 0.
product  output  2*WIDTH  current value of the P register.
busy  output  1  registered; high from the cycle after a ld_b with nonzero data until the cycle after B reaches 0.

Behaviour:
- Reset (rst low, asynchronous): A, B, P and busy go to 0. eqz therefore reads 1 and product reads 0.
- All register updates happen on the rising clk edge. Every control input is level-sampled at that edge.
- Register A:
  - ld_a=1: A <= data_in.
  - Otherwise A holds.
- Register B:
  - ld_b=1: B <= data_in. ld_b has priority over dec in the same cycle.
  - Else if dec=1 and B != 0: B <= B - 1.
  - dec with B == 0 is ignored: no wrap to all-ones.
- Register P:
  - clr=1: P <= 0. clr has priority over ld_p.
  - Else if ld_p=1 and B != 0: P <= P + {WIDTH'b0, A}.
  - ld_p with B == 0 is ignored. This guards against one extra accumulation in the cycle the FSM observes eqz.
- Simultaneous ld_a and ld_p: the accumulation uses the old A, i.e. the value before this edge.
- Overflow: none is possible. At most B_max additions of A_max are made, so P <= (2^W - 1)^2 < 2^(2W). No overflow flag is provided.
- eqz: purely combinational from B, zero latency. It rises in the same cycle B becomes 0 and stays high until the next ld_b with nonzero data.
- busy:
  - Set on the edge where ld_b=1 and data_in != 0.
  - Cleared on the edge where B transitions 1 -> 0 via dec, or on ld_b with data_in == 0.
- Latency:
  - With A and B loaded and P cleared, asserting ld_p and dec together for N = B cycles leaves product = A*B.
  - eqz is high at the start of the cycle after the Nth edge.
  - The first accumulation edge is the one after ld_b.
- Zero operand B: eqz stays high, ld_p/dec have no effect, product stays at its cleared value of 0.
- Zero operand A: accumulation runs N cycles adding 0; product = 0 and eqz still asserts after N cycles.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. No partial product survives. After rst deasserts, a new ld_a/ld_b/clr sequence is required.
- Recommended FSM sequence:
  - S1: ld_a
  - S2: ld_b + clr
  - S3: ld_p + dec until eqz
  - S4: hold
- Outputs in S4 are stable indefinitely.

Test Plan:
- Basic multiply, W=8:
  - Stimulus: data_in=5 with ld_a, then data_in=3 with ld_b+clr, then ld_p+dec for 3 cycles.
  - Required: B counts 3, 2, 1, 0; P counts 5, 10, 15.
  - Required: eqz=1 and busy=0 after the 3rd edge; product=15 (0x000F).
- Zero multiplier: A=9, ld_b with data_in=0, then ld_p+dec held for 4 cycles -> eqz=1 throughout, busy never set, product=0, B stays 0.
- Maximum operands: A=255, B=255, ld_p+dec for 255 cycles -> product=65025 (0xFE01), eqz rises after exactly 255 accumulation edges, no wrap.
- Guarding:
  - Hold ld_p+dec 2 extra cycles after eqz=1 in the A=5, B=3 case -> product stays 15, B stays 0.
  - Same cycle clr+ld_p -> P=0.
  - Same cycle ld_b(7)+dec -> B=7.
- Reset mid-operation: assert rst low asynchronously between edges during accumulation at A=4, B=6, P=8 -> A=B=P=0, eqz=1, busy=0 immediately. A new 2*2 run then yields product=4.
- Back-to-back runs: 6*7 -> 42, then without reset reload with clr for 3*3 -> 9. P is correctly cleared and no stale value of 42 carries into the second run.
